// File: rtl/ps2_pkg.sv
// ============================================================================
// Module : ps2_pkg
// Shared frame constants, parameter defaults and FSM state type for the
// PS/2 keyboard receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

  localparam int FILTER_LEN_DEF  = 8;
  localparam int TIMEOUT_CYC_DEF = 50000;
  localparam int FIFO_DEPTH_DEF  = 8;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = FRAME_BITS - 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                         input logic                 par);
    return ^{data, par};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_sync_filter.sv
// ============================================================================
// Module : ps2_sync_filter
// Double-flop synchroniser for PS/2 clock and data, glitch filter on the
// clock and a one-cycle falling-edge strobe of the filtered clock.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk_chipset,
  input  logic rst_n,
  input  logic ps2_clk_raw,
  input  logic ps2_data_raw,
  output logic data_sync,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    clk_meta;
  logic [1:0]    data_meta;
  logic          clk_sync;
  logic          clk_filt;
  logic [CW-1:0] cnt;

  assign clk_sync  = clk_meta[1];
  assign data_sync = data_meta[1];

  always_ff @(posedge clk_chipset or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta  <= 2'b11;
      data_meta <= 2'b11;
    end else begin
      clk_meta  <= {clk_meta[0], ps2_clk_raw};
      data_meta <= {data_meta[0], ps2_data_raw};
    end
  end

  // cnt counts consecutive disagreeing samples; the FILTER_LEN-th one flips
  always_ff @(posedge clk_chipset or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      cnt      <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync == clk_filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync;
        cnt      <= '0;
        fall     <= clk_filt;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
// ============================================================================
// Module : ps2_kbd_rx
// PS/2 keyboard receiver: frame FSM, timeout, host inhibit and byte storage.
// Define PS2_KBD_RX_FIFO_EN for a FIFO_DEPTH-entry FWFT FIFO; otherwise a
// single holding register is used.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic       clk_chipset,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       kbd_inhibit,
  output logic       ps2_clk_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       err_pulse,
  output logic       ovf_pulse
);

  localparam int         TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic          data_s;
  logic          fall;
  ps2_state_e    state;
  ps2_state_e    state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_ok;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          push;
  logic          frame_err;
  logic          pop;
  logic          ovf;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_filter (
    .clk_chipset  (clk_chipset),
    .rst_n        (rst_n),
    .ps2_clk_raw  (ps2_clk_i),
    .ps2_data_raw (ps2_data_i),
    .data_sync    (data_s),
    .fall         (fall)
  );

  assign tmo_hit = (state != ST_IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_chipset or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Inhibit outranks timeout so an inhibited partial frame leaves silently
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    frame_err = 1'b0;
    if (kbd_inhibit) begin
      state_nxt = ST_IDLE;
    end else if (tmo_hit) begin
      state_nxt = ST_IDLE;
      frame_err = 1'b1;
    end else if (fall) begin
      case (state)
        ST_IDLE:   if (!data_s) state_nxt = ST_DATA;
        ST_DATA:   if (bit_cnt == LAST_BIT) state_nxt = ST_PARITY;
        ST_PARITY: state_nxt = ST_STOP;
        ST_STOP: begin
          state_nxt = ST_IDLE;
          if (data_s && par_ok) push = 1'b1;
          else                  frame_err = 1'b1;
        end
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_chipset or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shift   <= '0;
      par_ok  <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (state_nxt == ST_IDLE || fall) tmo_cnt <= '0;
      else                              tmo_cnt <= tmo_cnt + TW'(1);

      if (fall && !kbd_inhibit) begin
        case (state)
          ST_IDLE:   bit_cnt <= '0;
          ST_DATA: begin
            shift   <= {data_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: par_ok <= odd_parity_ok(shift, data_s);
          default:   ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_chipset or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse  <= 1'b0;
      ovf_pulse  <= 1'b0;
      ps2_clk_oe <= 1'b0;
    end else begin
      err_pulse  <= frame_err;
      ovf_pulse  <= ovf;
      ps2_clk_oe <= kbd_inhibit;
    end
  end

  assign pop = rx_valid && rx_ready;

`ifdef PS2_KBD_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_valid = !empty;
  assign rx_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  // A pop in the same cycle frees the slot the full-FIFO push lands in
  assign push_ok  = push && (!full || pop);
  assign ovf      = push && full && !pop;

  always_ff @(posedge clk_chipset) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= shift;
  end

  always_ff @(posedge clk_chipset or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
`else
  logic [7:0] hold_data;
  logic       hold_valid;
  logic       unused_depth;

  assign unused_depth = (FIFO_DEPTH > 0);
  assign rx_valid     = hold_valid;
  assign rx_data      = hold_data;
  assign ovf          = push && hold_valid && !rx_ready;

  always_ff @(posedge clk_chipset or negedge rst_n) begin
    if (!rst_n) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (push && (!hold_valid || pop)) begin
      hold_data  <= shift;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
// ============================================================================
// Module : tb_ps2_kbd_rx
// Directed bench for ps2_kbd_rx with a byte scoreboard fed by the frame driver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_kbd_rx;

  localparam int FLEN  = 4;
  localparam int TMO   = 400;
  localparam int DEPTH = 8;
  localparam int HALF  = 40;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       inhibit  = 1'b0;
  logic       rx_ready = 1'b1;
  logic       oe;
  logic       rx_valid;
  logic       err_pulse;
  logic       ovf_pulse;
  logic [7:0] rx_data;

  int n_assert = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int ovf_cnt  = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  ps2_kbd_rx #(
    .FILTER_LEN  (FLEN),
    .TIMEOUT_CYC (TMO),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_chipset (clk),
    .rst_n       (rst_n),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .kbd_inhibit (inhibit),
    .ps2_clk_oe  (oe),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .err_pulse   (err_pulse),
    .ovf_pulse   (ovf_pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Consumer side of the scoreboard, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_pulse) err_cnt++;
      if (ovf_pulse) ovf_cnt++;
      if (rx_valid && rx_ready) begin
        check("rx_expected_avail", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) check("rx_byte", {24'd0, rx_data}, {24'd0, sb.pop_front()});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic par, input logic stop,
                           input int nbits, input bit glitch);
    logic [10:0] fr;
    fr = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      if (glitch) begin cyc(10); ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1; cyc(HALF - 13); end
      else cyc(HALF);
      ps2_clk = 1'b0;
      if (glitch) begin cyc(10); ps2_clk = 1'b1; cyc(3); ps2_clk = 1'b0; cyc(HALF - 13); end
      else cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
    send_bits(b, (~^b) ^ bad_par, 1'b1, 11, glitch);
    ps2_data = 1'b1;
    cyc(2 * HALF);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int o0;

    // Reset values, with inhibit requested while still in reset
    inhibit = 1'b1;
    cyc(5);
    check("rst_rx_data", {24'd0, rx_data}, 32'h0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_err", {31'd0, err_pulse}, 32'd0);
    check("rst_ovf", {31'd0, ovf_pulse}, 32'd0);
    check("rst_oe", {31'd0, oe}, 32'd0);
    inhibit = 1'b0;
    rst_n   = 1'b1;
    cyc(5);

    // Good frame 0x1C
    e0 = err_cnt;
    sb.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("good_1c_received", 32'(sb.size()), 32'd0);
    check("good_1c_no_err", 32'(err_cnt - e0), 32'd0);

    // Bad parity 0x1C
    e0 = err_cnt;
    rx_ready = 1'b0;
    send_frame(8'h1C, 1'b1, 1'b0);
    check("badpar_err_once", 32'(err_cnt - e0), 32'd1);
    check("badpar_no_valid", {31'd0, rx_valid}, 32'd0);

    // Bad stop bit
    e0 = err_cnt;
    send_bits(8'h33, ~^8'h33, 1'b0, 11, 1'b0);
    ps2_data = 1'b1;
    cyc(2 * HALF);
    check("badstop_err_once", 32'(err_cnt - e0), 32'd1);
    check("badstop_no_valid", {31'd0, rx_valid}, 32'd0);
    rx_ready = 1'b1;

    // Clock stops mid-frame, then a clean 0xF0
    e0 = err_cnt;
    send_bits(8'h77, ~^8'h77, 1'b1, 5, 1'b0);
    cyc(2 * TMO);
    check("timeout_err_once", 32'(err_cnt - e0), 32'd1);
    sb.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b0);
    check("after_timeout_f0", 32'(sb.size()), 32'd0);
    check("after_timeout_no_err", 32'(err_cnt - e0), 32'd1);

    // Glitches on the clock line
    e0 = err_cnt;
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1);
    check("glitch_5a_received", 32'(sb.size()), 32'd0);
    check("glitch_no_err", 32'(err_cnt - e0), 32'd0);

    // Host inhibit after 5 bits
    e0 = err_cnt;
    send_bits(8'h44, ~^8'h44, 1'b1, 5, 1'b0);
    inhibit = 1'b1;
    cyc(4);
    check("inhibit_oe_high", {31'd0, oe}, 32'd1);
    cyc(2 * TMO);
    check("inhibit_no_err", 32'(err_cnt - e0), 32'd0);
    check("inhibit_no_valid", {31'd0, rx_valid}, 32'd0);
    inhibit = 1'b0;
    cyc(4);
    check("release_oe_low", {31'd0, oe}, 32'd0);
    sb.push_back(8'h29);
    send_frame(8'h29, 1'b0, 1'b0);
    check("after_inhibit_29", 32'(sb.size()), 32'd0);

    // Reset mid-frame
    e0 = err_cnt;
    send_bits(8'h66, ~^8'h66, 1'b1, 5, 1'b0);
    rst_n = 1'b0;
    cyc(3);
    check("midrst_no_valid", {31'd0, rx_valid}, 32'd0);
    rst_n = 1'b1;
    cyc(2 * TMO);
    check("midrst_no_err", 32'(err_cnt - e0), 32'd0);
    sb.push_back(8'h12);
    send_frame(8'h12, 1'b0, 1'b0);
    check("after_midrst_12", 32'(sb.size()), 32'd0);

    // Storage overflow with the consumer stalled
    rx_ready = 1'b0;
    o0 = ovf_cnt;
`ifdef PS2_KBD_RX_FIFO_EN
    for (int i = 1; i <= 8; i++) begin
      sb.push_back(8'(i));
      send_frame(8'(i), 1'b0, 1'b0);
    end
    check("fifo_fill_no_ovf", 32'(ovf_cnt - o0), 32'd0);
    send_frame(8'h09, 1'b0, 1'b0);
    check("fifo_ovf_on_09", 32'(ovf_cnt - o0), 32'd1);
`else
    sb.push_back(8'h01);
    send_frame(8'h01, 1'b0, 1'b0);
    check("hold_first_no_ovf", 32'(ovf_cnt - o0), 32'd0);
    send_frame(8'h02, 1'b0, 1'b0);
    check("hold_ovf_on_02", 32'(ovf_cnt - o0), 32'd1);
`endif
    check("stall_valid", {31'd0, rx_valid}, 32'd1);
    check("stall_data", {24'd0, rx_data}, 32'h01);
    cyc(20);
    check("stall_data_stable", {24'd0, rx_data}, 32'h01);
    rx_ready = 1'b1;
    cyc(20);
    check("drain_done", 32'(sb.size()), 32'd0);
    check("drain_valid_low", {31'd0, rx_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL take parameter FILTER_LEN, default 8, as the number of consecutive equal samples needed to accept a PS/2 clock level change.
REQ-002 SHALL take parameter TIMEOUT_CYC, default 50000, as the maximum clk_chipset cycles allowed between falling edges inside a frame (1 ms at 50 MHz).
REQ-003 SHALL take parameter FIFO_DEPTH, default 8, power of two, as the receive FIFO depth.
REQ-004 SHALL have port clk_chipset, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port ps2_clk_i, input, 1 bit: raw PS/2 clock from the pad (asynchronous).
REQ-007 SHALL have port ps2_data_i, input, 1 bit: raw PS/2 data from the pad (asynchronous).
REQ-008 SHALL have port kbd_inhibit, input, 1 bit: when high, the host inhibits the keyboard.
REQ-009 SHALL have port ps2_clk_oe, output, 1 bit: when high, the pad drives PS/2 clock low.
REQ-010 SHALL have port rx_data, output, 8 bits: received scancode byte.
REQ-011 SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-012 SHALL have port rx_ready, input, 1 bit: the consumer accepts rx_data this cycle.
REQ-013 SHALL have port err_pulse, output, 1 bit: one-cycle pulse on a parity, stop-bit or timeout error.
REQ-014 SHALL have port ovf_pulse, output, 1 bit: one-cycle pulse when a good byte is dropped because storage is full.

Function
REQ-015 SHALL synchronise ps2_clk_i and ps2_data_i through 2 flip-flops each before any use.
REQ-016 SHALL change the filtered clock only after FILTER_LEN consecutive synchronised samples disagree with its current value.
REQ-017 SHALL sample synchronised data on each filtered-clock falling edge.
REQ-018 SHALL implement the frame FSM as follows:
- IDLE: edge with data=0 goes to DATA; edge with data=1 is ignored.
- DATA: shift in 8 bits LSB first, then go to PARITY.
- PARITY: record odd-parity OK, then go to STOP.
- STOP: always return to IDLE.
REQ-019 SHALL push the byte when the STOP edge has data=1 and parity OK; otherwise it SHALL pulse err_pulse and discard the byte.
REQ-020 SHALL present a pushed byte on rx_data with rx_valid high 1 cycle after the STOP-edge detect cycle when storage was empty.
REQ-021 SHALL, when outside IDLE with no falling edge for TIMEOUT_CYC cycles, return to IDLE, pulse err_pulse and discard the partial frame.
REQ-022 SHALL, while kbd_inhibit=1, hold ps2_clk_oe=1, force IDLE and silently discard any partial frame, while preserving already-stored bytes.
REQ-023 SHALL complete a transfer in every cycle where rx_valid=1 and rx_ready=1; rx_ready is ignored when rx_valid=0.
REQ-024 SHALL keep rx_data stable while rx_valid=1 and rx_ready=0.

Reset
REQ-025 SHALL, while rst_n=0, force:
- rx_data=0, rx_valid=0, err_pulse=0, ovf_pulse=0, ps2_clk_oe=0;
- FSM=IDLE, bit and timeout counters=0, storage empty;
- filtered clock and synchroniser flops=1 (idle bus).
REQ-026 SHALL, on reset asserted mid-frame, discard the frame with no error pulse after release.

Configuration
REQ-027 SHALL, with PS2_KBD_RX_FIFO_EN defined, buffer bytes in a FIFO_DEPTH-entry FIFO with first-word fall-through:
- push when full drops the new byte and pulses ovf_pulse;
- push and pop in the same cycle when full is accepted without overflow.
REQ-028 SHALL, without PS2_KBD_RX_FIFO_EN, use a single holding register:
- push while rx_valid=1 and rx_ready=0 drops the new byte and pulses ovf_pulse;
- push in the same cycle as a consume is accepted.

Structure
REQ-029 SHALL take the FSM state enum, the FILTER_LEN/TIMEOUT_CYC/FIFO_DEPTH defaults and the frame bit count (11) from shared package ps2_pkg.
REQ-030 SHALL place the synchroniser, glitch filter and falling-edge detector in sub-module ps2_sync_filter.

Verification
REQ-031 SHALL check a valid frame for byte 0x1C (parity bit 0) at 12 kHz: rx_data=0x1C with rx_valid=1 after STOP, and err_pulse never asserted.
REQ-032 SHALL check a frame for 0x1C with parity bit 1: err_pulse pulses once and rx_valid stays 0.
REQ-033 SHALL check clock stopping for 2×TIMEOUT_CYC after bit 4: err_pulse pulses once, then the next valid 0xF0 frame is received correctly.
REQ-034 SHALL, with FIFO enabled, check 9 frames 0x01..0x09 sent while rx_ready=0: ovf_pulse pulses once on 0x09, then reads return 0x01..0x08 in order.
REQ-035 SHALL check 3-cycle glitches injected on ps2_clk_i during a 0x5A frame: the byte is still 0x5A and no extra bits are shifted.
REQ-036 SHALL check kbd_inhibit=1 asserted after 5 bits: ps2_clk_oe=1, no err_pulse, and the next full 0x29 frame is received.
